// File: rtl/div_unit_pkg.sv
// Shared types for the iterative RV32M divide/remainder unit: operation and
// state encodings, datapath width, step count and small decode helpers.
package div_unit_pkg;

    localparam int DIV_W     = 32;
    localparam int DIV_STEPS = 32;

    typedef logic [DIV_W-1:0] word_t;

    typedef enum logic [1:0] {
        DIV_S = 2'b00,
        DIVU  = 2'b01,
        REM_S = 2'b10,
        REMU  = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Bit 0 of the opcode marks unsigned, bit 1 selects the remainder.
    function automatic logic op_signed(div_op_e op);
        return ~op[0];
    endfunction

    function automatic logic op_rem(div_op_e op);
        return op[1];
    endfunction

    function automatic word_t abs_w(word_t v);
        return v[DIV_W-1] ? -v : v;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// EX-stage side-band between the pipeline and the divide unit: request,
// operands and flush in; stall request, done pulse and result out.
interface div_unit_if;
    import div_unit_pkg::*;

    logic    start;
    div_op_e DivOp;
    word_t   Operand1;
    word_t   Operand2;
    logic    flush;
    logic    StallReq;
    logic    done;
    word_t   DivOut;

    modport master (
        output start, DivOp, Operand1, Operand2, flush,
        input  StallReq, done, DivOut
    );

    modport slave (
        input  start, DivOp, Operand1, Operand2, flush,
        output StallReq, done, DivOut
    );

endinterface

// File: rtl/div_unit_step.sv
// One restoring radix-2 iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, shift the outcome into quo.
module div_unit_step
    import div_unit_pkg::*;
(
    input  word_t rem_i,
    input  word_t quo_i,
    input  word_t dvs_i,
    output word_t rem_o,
    output word_t quo_o
);

    logic [DIV_W:0] shifted;
    logic [DIV_W:0] diff;

    assign shifted = {rem_i, quo_i[DIV_W-1]};
    assign diff    = shifted - {1'b0, dvs_i};

    // rem_i < dvs_i always holds, so whichever value is kept fits in 32 bits.
    always_comb begin
        rem_o = shifted[DIV_W-1:0];
        quo_o = {quo_i[DIV_W-2:0], 1'b0};
        if (!diff[DIV_W]) begin
            rem_o = diff[DIV_W-1:0];
            quo_o = {quo_i[DIV_W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU for EX: 33 cycles start-to-done (1 for divide-by-zero/overflow).
// Latency: 32 CALC cycles then a one-cycle done pulse with DivOut registered.
// Backpressure: StallReq freezes IF/ID/EX while busy; flush aborts to IDLE at the next edge.
module div_unit
    import div_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  dif
);

    div_state_e state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    word_t      rem_q, rem_d;
    word_t      quo_q, quo_d;
    word_t      dvs_q, dvs_d;
    word_t      out_q, out_d;
    div_op_e    op_q, op_d;
    logic       qneg_q, qneg_d;
    logic       rneg_q, rneg_d;
    logic       done_q, done_d;

    word_t step_rem;
    word_t step_quo;

    div_unit_step u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    logic  in_signed;
    logic  div_zero;
    logic  sgn_ovf;
    logic  accept;
    word_t special_res;
    word_t final_res;

    always_comb begin
        in_signed = op_signed(dif.DivOp);
        div_zero  = (dif.Operand2 == '0);
        sgn_ovf   = in_signed && (dif.Operand1 == 32'h8000_0000)
                              && (dif.Operand2 == 32'hFFFF_FFFF);
        accept    = (state_q == DIV_IDLE) && dif.start && !dif.flush;

        // Divide-by-zero keeps the raw dividend as remainder, even for signed ops.
        if (div_zero) begin
            special_res = op_rem(dif.DivOp) ? dif.Operand1 : 32'hFFFF_FFFF;
        end else begin
            special_res = op_rem(dif.DivOp) ? 32'h0 : 32'h8000_0000;
        end

        if (op_rem(op_q)) begin
            final_res = rneg_q ? -step_rem : step_rem;
        end else begin
            final_res = qneg_q ? -step_quo : step_quo;
        end
    end

    assign dif.StallReq = (state_q == DIV_CALC) || accept;
    assign dif.done     = done_q;
    assign dif.DivOut   = out_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        out_d   = out_q;
        op_d    = op_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        done_d  = 1'b0;

        if (dif.flush) begin
            state_d = DIV_IDLE;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (dif.start) begin
                        op_d = dif.DivOp;
                        if (div_zero || sgn_ovf) begin
                            out_d   = special_res;
                            done_d  = 1'b1;
                            state_d = DIV_DONE;
                        end else begin
                            rem_d   = '0;
                            quo_d   = in_signed ? abs_w(dif.Operand1) : dif.Operand1;
                            dvs_d   = in_signed ? abs_w(dif.Operand2) : dif.Operand2;
                            qneg_d  = in_signed && (dif.Operand1[DIV_W-1] ^ dif.Operand2[DIV_W-1]);
                            rneg_d  = in_signed && dif.Operand1[DIV_W-1];
                            cnt_d   = '0;
                            state_d = DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + 6'd1;
                    // The 32nd step's result goes straight into DivOut.
                    if (cnt_q == 6'(DIV_STEPS - 1)) begin
                        out_d   = final_res;
                        done_d  = 1'b1;
                        state_d = DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    state_d = DIV_IDLE;
                end
                default: begin
                    state_d = DIV_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            out_q   <= '0;
            op_q    <= DIV_S;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            out_q   <= out_d;
            op_q    <= op_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: cycle-exact stall/done timing, signed and
// unsigned results, special cases, flush, reset and back-to-back requests.
module tb_div_unit;
    import div_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_unit_if dif ();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .dif (dif)
    );

    int    checks = 0;
    int    errors = 0;
    word_t last   = '0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request in the current (IDLE) cycle and follows it to the done cycle.
    task automatic do_op(input string tag, input div_op_e op, input word_t a, input word_t b,
                         input word_t exp, input bit special, input bit toggle);
        int n = special ? 1 : 33;
        chk({tag, "_no_done_before"}, 32'(dif.done), 32'h0);
        dif.start    = 1'b1;
        dif.DivOp    = op;
        dif.Operand1 = a;
        dif.Operand2 = b;
        #1;
        chk({tag, "_stall_c0"}, 32'(dif.StallReq), 32'h1);
        tick();
        dif.start    = 1'b0;
        dif.Operand1 = $urandom;
        dif.Operand2 = $urandom;
        dif.DivOp    = div_op_e'(~2'(op));
        for (int k = 1; k < n; k++) begin
            if (toggle) dif.start = (k >= 5 && k <= 15) ? k[0] : 1'b0;
            #1;
            chk({tag, "_busy_stall_nodone"}, {30'b0, dif.StallReq, dif.done}, 32'h2);
            tick();
        end
        dif.start = 1'b0;
        #1;
        chk({tag, "_done"}, 32'(dif.done), 32'h1);
        chk({tag, "_stall_in_done"}, 32'(dif.StallReq), 32'h0);
        chk({tag, "_result"}, dif.DivOut, exp);
        last = exp;
        tick();
    endtask

    initial begin
        rst          = 1'b1;
        dif.start    = 1'b0;
        dif.flush    = 1'b0;
        dif.DivOp    = DIVU;
        dif.Operand1 = '0;
        dif.Operand2 = '0;
        tick();
        tick();
        chk("reset_divout", dif.DivOut, 32'h0);
        chk("reset_done", 32'(dif.done), 32'h0);
        chk("reset_stall", 32'(dif.StallReq), 32'h0);
        rst = 1'b0;
        tick();

        do_op("divu_100_7",   DIVU,  32'd100,       32'd7,         32'd14,        1'b0, 1'b0);
        do_op("remu_100_7",   REMU,  32'd100,       32'd7,         32'd2,         1'b0, 1'b0);
        do_op("div_m7_2",     DIV_S, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 1'b0);
        do_op("rem_m7_2",     REM_S, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op("rem_7_m2",     REM_S, 32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0, 1'b0);
        do_op("divu_80_ff",   DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0);
        do_op("div_ovf",      DIV_S, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0);
        do_op("rem_ovf",      REM_S, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0);
        do_op("divu_5_0",     DIVU,  32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, 1'b0);
        do_op("remu_5_0",     REMU,  32'd5,         32'd0,         32'd5,         1'b1, 1'b0);
        do_op("rem_m5_0",     REM_S, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1'b1, 1'b0);

        // Flush in cycle 10 of DIVU 1000/3.
        dif.start    = 1'b1;
        dif.DivOp    = DIVU;
        dif.Operand1 = 32'd1000;
        dif.Operand2 = 32'd3;
        #1;
        chk("flush_op_stall_c0", 32'(dif.StallReq), 32'h1);
        tick();
        dif.start = 1'b0;
        repeat (9) tick();
        dif.flush = 1'b1;
        tick();
        dif.flush = 1'b0;
        #1;
        chk("flush_idle_stall", 32'(dif.StallReq), 32'h0);
        chk("flush_no_done", 32'(dif.done), 32'h0);
        chk("flush_divout_kept", dif.DivOut, last);
        tick();
        do_op("divu_9_3_after_flush", DIVU, 32'd9, 32'd3, 32'd3, 1'b0, 1'b0);

        // Flush and start together in IDLE.
        dif.flush    = 1'b1;
        dif.start    = 1'b1;
        dif.DivOp    = DIVU;
        dif.Operand1 = 32'd8;
        dif.Operand2 = 32'd2;
        #1;
        chk("flush_start_stall", 32'(dif.StallReq), 32'h0);
        tick();
        dif.flush = 1'b0;
        dif.start = 1'b0;
        #1;
        chk("flush_start_not_busy", 32'(dif.StallReq), 32'h0);
        chk("flush_start_no_done_c1", 32'(dif.done), 32'h0);
        tick();
        chk("flush_start_no_done_c2", 32'(dif.done), 32'h0);
        chk("flush_start_divout", dif.DivOut, last);

        // Reset in cycle 20 of an active divide.
        dif.start    = 1'b1;
        dif.DivOp    = DIVU;
        dif.Operand1 = 32'd50000;
        dif.Operand2 = 32'd7;
        tick();
        dif.start = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_divout", dif.DivOut, 32'h0);
        chk("rst_mid_done", 32'(dif.done), 32'h0);
        chk("rst_mid_stall", 32'(dif.StallReq), 32'h0);
        tick();
        chk("rst_mid_still_idle", 32'(dif.StallReq), 32'h0);

        do_op("divu_toggle_start", DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1);

        // Back-to-back: second start raised in the cycle after done.
        do_op("b2b_divu", DIVU, 32'hFFFF_FFFF, 32'd1,  32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op("b2b_remu", REMU, 32'hFFFF_FFFF, 32'h10, 32'hF,         1'b0, 1'b0);
        #1;
        chk("b2b_single_done", 32'(dif.done), 32'h0);
        chk("b2b_divout_held", dif.DivOut, 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative RV32M divide/remainder unit for the EX stage of the RISC-V pipeline CPU. It runs beside the ALU: takes the same Operand1/Operand2 from the ID/EX segment and a 2-bit divide opcode. It produces DivOut, which the EX result mux selects in place of AluOut for DIV/DIVU/REM/REMU. While a division is in flight it raises a stall request to the hazard unit, freezing IF/ID/EX until the result is ready.

## Interface
- No parameters; width fixed at 32.
- clk  in  1  core clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  EX holds a divide instruction; sampled only in IDLE.
- DivOp  in  2  operation: `DIV_S`, `DIVU`, `REM_S`, `REMU`.
- Operand1  in  32  dividend (rs1).
- Operand2  in  32  divisor (rs2).
- flush  in  1  synchronous abort from the hazard unit (flushE).
- StallReq  out  1  combinational: (state==CALC) | (state==IDLE & start & ~flush).
- done  out  1  registered; high exactly one cycle when DivOut is valid.
- DivOut  out  32  registered result; held until the next result or reset.

## Operation
- States:
  - IDLE: wait for start.
  - CALC: one restoring radix-2 step per cycle, 32 steps; 6-bit counter.
  - DONE: done=1 for one cycle, then return to IDLE.
- IDLE & start:
  - Latch the operation.
  - Latch |Operand1| and |Operand2| for signed ops, raw values for unsigned ops.
  - Latch the quotient sign (signs differ) and the remainder sign (dividend sign).
- Special cases: resolved at start, skip CALC, go to DONE.
  - Divisor 0: quotient 0xFFFFFFFF (all ops); remainder = Operand1 unchanged.
  - Signed overflow (0x80000000 / 0xFFFFFFFF, DIV_S/REM_S): quotient 0x80000000, remainder 0.
- CALC step:
  - rem' = {rem[31:0], quo[31]}.
  - If rem' ≥ divisor: subtract and shift a 1 into quo; else shift a 0.
  - Use a 33-bit subtract; no 64-bit datapath.
- CALC → DONE: after step 32, on the same edge that loads DivOut.
  - DivOut = quotient or remainder by op.
  - Negate the quotient if its sign flag is set; negate the remainder if the dividend sign flag is set (signed ops only).
- DONE → IDLE unconditionally.
  - A start seen in DONE is not accepted. The pipeline advances on the done cycle, so a back-to-back divide reaches IDLE in the next cycle.
- start outside IDLE is ignored; operands need not be held stable after the accepting cycle.
- flush: any state → IDLE next edge; done not asserted; DivOut unchanged.
  - flush & start in the same IDLE cycle: flush wins, nothing accepted.
- rst: any state → IDLE.
  - DivOut=0, done=0, counter=0.
  - StallReq=0 while start=0.

## Timing
- Cycle 0 is the cycle where IDLE & start are sampled. StallReq=1 in cycle 0, combinationally.
- Normal op:
  - CALC in cycles 1–32, StallReq=1.
  - DONE in cycle 33: done=1, StallReq=0, DivOut valid.
  - Total: 33 stall cycles.
- Special case: DONE in cycle 1, done=1; 1 stall cycle (cycle 0).
- The EX/MEM segment captures DivOut on the edge ending the done cycle.
- No combinational path from Operand1/Operand2 to any output.

## Structure
- Shared header Parameters.v:
  - DivOp encodings `DIV_S`=2'b00, `DIVU`=2'b01, `REM_S`=2'b10, `REMU`=2'b11.
  - State encodings `DIV_IDLE`, `DIV_CALC`, `DIV_DONE`.
  - Iteration count `DIV_STEPS`=32.
- Single module div_unit: FSM, counter, rem/quo/divisor registers.
- One natural combinational sub-module, div_step: one compare-subtract-shift iteration; inputs {rem, quo, divisor}, outputs next {rem, quo}.

## Test plan
- DIVU 100/7, start in cycle 0 → StallReq high cycles 0–32; done only in cycle 33; DivOut=14. REMU same operands → 2.
- DIV_S 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD (-3). REM_S same operands → 0xFFFFFFFF (-1). REM_S 7/-2 → 1.
- DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; both with done in cycle 1. DIV_S 0x80000000/0xFFFFFFFF → 0x80000000; REM_S same → 0; both done in cycle 1.
- Start DIVU 1000/3, flush in cycle 10:
  - Required: IDLE in cycle 11, no done, DivOut keeps its old value.
  - New start DIVU 9/3 in cycle 12 → done in cycle 45, DivOut=3.
  - flush & start together in IDLE → StallReq=0, no done.
- Start a divide, assert rst in cycle 20 → cycle 21: IDLE, DivOut=0, done=0. start toggled in cycles 5–15 of an active op → ignored, result unaffected.
- Back-to-back DIVU 0xFFFFFFFF/1 then REMU 0xFFFFFFFF/0x10 (second start raised the cycle after done) → 0xFFFFFFFF, then 0xF; exactly one done pulse each.
